// File: rtl/lead_one_expander.sv
// Rebuilds a value from a normalized mantissa by placing its leading one at bit
// `pos`. It does this with an iterative right shift of one bit per cycle.
// The optional macro LOE_ROUND_EN rounds half-up on the last bit shifted out.
module lead_one_expander #(
  parameter int WIDTH   = 16,
  parameter int POS_W   = 4,
  parameter int MIN_POS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [POS_W-1:0] pos,
  input  logic [WIDTH-1:0] mant,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             underflow
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [POS_W-1:0] MAX_POS = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] MIN_P   = POS_W'(MIN_POS);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] final_val;

`ifdef LOE_ROUND_EN
  logic guard_q, guard_d;
  // After at least one shift the MSB is zero, so adding the guard bit cannot overflow.
  assign final_val = shreg_q + {{(WIDTH-1){1'b0}}, guard_q};
`else
  assign final_val = shreg_q;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    underflow_d = underflow_q;
`ifdef LOE_ROUND_EN
    guard_d     = guard_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        if (pos < MIN_P) begin
          result_d    = '0;
          underflow_d = 1'b1;
          state_d     = DONE;
        end else begin
          shreg_d = mant;
          cnt_d   = MAX_POS - pos;
`ifdef LOE_ROUND_EN
          guard_d = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: if (cnt_q != '0) begin
`ifdef LOE_ROUND_EN
        guard_d = shreg_q[0];
`endif
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q - POS_W'(1);
      end else begin
        result_d    = final_val;
        underflow_d = 1'b0;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      underflow_q <= 1'b0;
`ifdef LOE_ROUND_EN
      guard_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      underflow_q <= underflow_d;
`ifdef LOE_ROUND_EN
      guard_q     <= guard_d;
`endif
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lead_one_expander.sv
// Bench for lead_one_expander: directed and random jobs checked against an
// arithmetic reference (divide by 2**k, optional round-half-up).
module tb_lead_one_expander;
  localparam int WIDTH = 16, POS_W = 4, MIN_POS = 8;

  logic             clk, rst_n, start;
  logic [POS_W-1:0] pos;
  logic [WIDTH-1:0] mant;
  logic             busy, done, underflow;
  logic [WIDTH-1:0] result;

  int n_chk = 0, n_err = 0;

  lead_one_expander #(.WIDTH(WIDTH), .POS_W(POS_W), .MIN_POS(MIN_POS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pos(pos), .mant(mant),
    .busy(busy), .done(done), .result(result), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_res(input logic [WIDTH-1:0] m, input int p);
    int k;
    if (p < MIN_POS) return '0;
    k = WIDTH - 1 - p;
`ifdef LOE_ROUND_EN
    if (k > 0) return WIDTH'((int'(m) + (1 << (k - 1))) >> k);
`endif
    return WIDTH'(int'(m) >> k);
  endfunction

  function automatic int ref_lat(input int p);
    return (p < MIN_POS) ? 0 : (WIDTH - p);
  endfunction

  // Issue one job from IDLE and check result, underflow, latency, busy span and pulse width.
  task automatic run_job(input string tag, input logic [WIDTH-1:0] m, input int p);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; pos = POS_W'(p); mant = m;
    @(posedge clk);
    #1 start = 1'b0;
    pos = POS_W'($urandom); mant = WIDTH'($urandom);
    lat = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) break;
      lat++;
      if (lat > 40) break;
    end
    chk({tag, ".res"}, 32'(result), 32'(ref_res(m, p)));
    chk({tag, ".uf"}, 32'(underflow), 32'(p < MIN_POS));
    chk({tag, ".lat"}, 32'(lat), 32'(ref_lat(p)));
    chk({tag, ".busy"}, 32'(bcnt), 32'(ref_lat(p) + 1));
    @(negedge clk);
    chk({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    chk({tag, ".hold"}, 32'(result), 32'(ref_res(m, p)));
  endtask

  initial begin
    int dcnt, gap;
    logic [WIDTH-1:0] m;
    int p;
    rst_n = 1'b0; start = 1'b0; pos = '0; mant = '0;
    repeat (2) @(negedge clk);
    chk("rst", {busy, done, underflow, result}, 32'd0);
    rst_n = 1'b1;

    run_job("p15", 16'hC000, 15);
    run_job("p12", 16'hC000, 12);
    run_job("p8a", 16'h8001, 8);
    run_job("uf7", 16'hFFFF, 7);
    run_job("p8f", 16'hFFFF, 8);
    run_job("p14", 16'hC000, 14);
    run_job("uf0", 16'h8000, 0);

    // Start during SHIFT must be ignored
    @(negedge clk);
    start = 1'b1; pos = 4'd10; mant = 16'hB5A7;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk); @(negedge clk);
    start = 1'b1; pos = 4'd8; mant = 16'hFFFF;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        chk("ign.res", 32'(result), 32'(ref_res(16'hB5A7, 10)));
      end
    end
    chk("ign.ndone", 32'(dcnt), 32'd1);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; pos = 4'd8; mant = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1 chk("mrst", {busy, done, underflow, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst.quiet", {busy, done, underflow, result}, 32'd0);
    run_job("after", 16'h9234, 15);

    // Start held high: back-to-back pos=15 jobs issue every L+2 = 3 cycles
    @(negedge clk);
    start = 1'b1; pos = 4'd15; mant = 16'hA000;
    dcnt = 0; gap = 0;
    for (int i = 0; i < 30 && dcnt < 2; i++) begin
      @(negedge clk);
      if (dcnt == 1) gap++;
      if (done) dcnt++;
    end
    chk("b2b.gap", 32'(gap), 32'd3);
    start = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      m = WIDTH'($urandom) | 16'h8000;
      p = int'($urandom_range(0, 15));
      run_job($sformatf("rnd%0d", i), m, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/lead_one_expander.md
Name: lead_one_expander

Overview:
- Inverse of the leading-one position encoder used in the compensated divider datapath.
- Takes a normalized mantissa (leading one at bit WIDTH-1) and a 4-bit leading-one position, and rebuilds the value with its leading one placed at that position.
- Uses an iterative right shifter at one bit per cycle, with a start/busy/done handshake.
- Sits after the divider core, where it denormalizes the quotient using the position that the encoder extracted.

Parameters:
- WIDTH, 16, data width of mant/result.
- POS_W, 4, width of pos; must satisfy 2**POS_W == WIDTH.
- MIN_POS, 8, lowest legal position; positions below it produce a zero result, matching the encoder floor.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- pos  input  POS_W  target bit position of the leading one
- mant  input  WIDTH  normalized mantissa; MSB is expected to be 1 but is not checked
- busy  output  1  high in SHIFT and DONE
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  denormalized value; holds its value until the next completion
- underflow  output  1  valid with done; high when pos < MIN_POS

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, result=0, underflow=0, internal shift register=0, counter=0.
- Shift amount: k = WIDTH-1-pos (0..WIDTH-1), held in a POS_W-bit down-counter.
- IDLE, start=1 at edge E0:
  - pos >= MIN_POS: load shreg=mant, cnt=k, guard=0; go to SHIFT.
  - pos < MIN_POS: result=0, underflow=1; go to DONE.
- IDLE, start=0: stay in IDLE; all outputs hold.
- SHIFT:
  - cnt != 0: guard=shreg[0], shreg=shreg>>1 (logical, zero fill), cnt=cnt-1.
  - cnt == 0: result=shreg, underflow=0; go to DONE.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE.
- Latency: done is high in the cycle after edge E0+L.
  - Normal: L = k+1 (pos=15 gives L=1; pos=MIN_POS=8 gives L=8).
  - Underflow: L = 0.
- busy=1 from the edge after E0 until the edge that returns to IDLE; busy=0 in IDLE.
- start while busy=1 is ignored: no queuing, no effect on the operation in flight.
- start held high: a new operation is accepted on the first IDLE cycle after DONE. Minimum issue interval is L+2 edges.
- pos and mant are sampled only at E0; changes during SHIFT have no effect.
- rst_n asserted mid-operation: immediate return to reset values. done is not issued and the partial result is discarded.
- No intermediate value reaches the result register; result updates only on the SHIFT to DONE edge, or on the underflow path.

Optional Feature:
- Macro: LOE_ROUND_EN.
- Defined:
  - On the SHIFT to DONE transition, result = shreg + guard (round-half-up on the last bit shifted out).
  - Cannot overflow: k >= 1 whenever guard can be 1.
  - k=0 gives guard=0.
  - Latency is unchanged.
- Undefined: guard logic is absent; result = shreg (truncation).

Test Plan:
- Reset: mant=0xC000, pos=15, start at E0 -> done=1 in the cycle after E1, result=0xC000, underflow=0, busy=1 for exactly 2 cycles.
- Normal shift: mant=0xC000, pos=12 -> result=0x1800 after L=4; mant=0x8001, pos=8 -> result=0x0100, L=8, with and without rounding.
- Underflow: pos=7, mant=0xFFFF -> done in the cycle after E0, result=0x0000, underflow=1.
- Ignored start: start pulsed with pos=8 during SHIFT of a pos=10 job -> result matches the pos=10 job only, and exactly one done pulse.
- Reset mid-op: mant=0xFFFF, pos=8, rst_n low 3 cycles after start -> busy=0, done=0, result=0. A subsequent pos=15 job completes normally.
- Rounding: mant=0xFFFF, pos=8 (k=7) -> result=0x0200 with LOE_ROUND_EN, 0x01FF without; mant=0xC000, pos=14 -> 0x6000 in both builds.
